// File: rtl/step_pulse_gen_pkg.sv
// Shared types for the stepper pulse generator: FSM state encoding and the
// period/position word types.
package step_pkg;

    localparam int WIDTH_WORK = 16;

    typedef enum logic [1:0] {
        IDLE,
        DIR_WAIT,
        HIGH,
        LOW
    } step_state_e;

    typedef logic [WIDTH_WORK-1:0]        period_t;
    typedef logic signed [WIDTH_WORK-1:0] position_t;

endpackage

// File: rtl/step_pulse_gen_timer.sv
// Loadable down counter with a zero flag; one instance times the DIR_WAIT,
// HIGH and LOW phases of the step generator.
module step_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    assign zero = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (!zero) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/step_pulse_gen.sv
// Stepper pulse generator: atomic step pulses at the commanded period with
// direction setup and a wrapping signed position count. Optional STEP_RAMP_EN.
module step_pulse_gen
    import step_pkg::*;
#(
    parameter int PULSE_W    = 50,
    parameter int DIR_SETUP  = 250,
`ifdef STEP_RAMP_EN
    parameter int RAMP_STEP  = 16,
    parameter int RAMP_START = 4000,
`endif
    parameter int N_MIN      = 100
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      enable,
    input  logic      dir_in,
    input  period_t   period_in,
    input  logic      period_valid,
    input  logic      pos_clear,
    output logic      step_out,
    output logic      dir_out,
    output logic      busy,
    output position_t position
);

    localparam period_t N_MIN_P = period_t'(N_MIN);

    // state    | meaning
    // IDLE     | stopped, waiting for enable with a non-zero target
    // DIR_WAIT | dir_out updated, step held low for the setup time
    // HIGH     | step pulse high for PULSE_W cycles
    // LOW      | step low for the rest of the effective period
    step_state_e state_q, state_d;
    logic        step_q, step_d;
    logic        dir_q, dir_d;
    period_t     target_q, target_d;
    period_t     eff_q, eff_d;
    position_t   pos_q, pos_d;

    logic        enter_high;
    logic        tmr_load;
    period_t     tmr_val;
    logic        tmr_zero;
    period_t     step_period;

`ifdef STEP_RAMP_EN
    logic hold_q, hold_d;

    function automatic period_t ramp_toward(input period_t cur, input period_t tgt);
        period_t rs;
        rs = period_t'(RAMP_STEP);
        if (cur > tgt) begin
            return ((cur - tgt) > rs) ? cur - rs : tgt;
        end
        return ((tgt - cur) > rs) ? cur + rs : tgt;
    endfunction
`endif

    function automatic period_t clamp_period(input period_t p);
        if (p == '0) begin
            return '0;
        end else if (p < N_MIN_P) begin
            return N_MIN_P;
        end
        return p;
    endfunction

    // A target dropped to zero during DIR_WAIT still needs a legal LOW length.
    assign step_period = (target_q == '0) ? N_MIN_P : target_q;

    step_timer #(.W(WIDTH_WORK)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        eff_d      = eff_q;
        pos_d      = pos_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        enter_high = 1'b0;
        target_d   = period_valid ? clamp_period(period_in) : target_q;
`ifdef STEP_RAMP_EN
        hold_d     = hold_q;
`endif

        case (state_q)
            IDLE: begin
                if (enable && (target_q != '0)) begin
                    if (dir_in != dir_q) begin
                        state_d  = DIR_WAIT;
                        dir_d    = dir_in;
                        tmr_load = 1'b1;
                        tmr_val  = period_t'(DIR_SETUP - 1);
                    end else begin
                        enter_high = 1'b1;
                    end
                end
            end
            DIR_WAIT: begin
                if (tmr_zero) begin
                    enter_high = 1'b1;
                end
            end
            HIGH: begin
                if (tmr_zero) begin
                    state_d  = LOW;
                    tmr_load = 1'b1;
                    tmr_val  = eff_q - period_t'(PULSE_W + 1);
                end
            end
            LOW: begin
                if (tmr_zero) begin
                    if (!enable || (target_q == '0)) begin
                        state_d = IDLE;
                    end else if (dir_in != dir_q) begin
                        state_d  = DIR_WAIT;
                        dir_d    = dir_in;
                        tmr_load = 1'b1;
                        tmr_val  = period_t'(DIR_SETUP - 1);
                    end else begin
                        enter_high = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_high) begin
            state_d  = HIGH;
            tmr_load = 1'b1;
            tmr_val  = period_t'(PULSE_W - 1);
            pos_d    = dir_q ? pos_q + position_t'(1) : pos_q - position_t'(1);
        end

`ifdef STEP_RAMP_EN
        // The IDLE-exit period is used as-is by the first pulse, ramping after.
        if ((state_q == IDLE) && (state_d != IDLE)) begin
            eff_d  = (target_q > period_t'(RAMP_START)) ? target_q : period_t'(RAMP_START);
            hold_d = (state_d == DIR_WAIT);
        end else if (enter_high) begin
            if (hold_q) begin
                hold_d = 1'b0;
            end else if (target_q != '0) begin
                eff_d = ramp_toward(eff_q, target_q);
            end
        end
`else
        if (enter_high) begin
            eff_d = step_period;
        end
`endif

        if (pos_clear) begin
            pos_d = '0;
        end

        step_d = (state_d == HIGH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            target_q <= '0;
            eff_q    <= '0;
            pos_q    <= '0;
`ifdef STEP_RAMP_EN
            hold_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            target_q <= target_d;
            eff_q    <= eff_d;
            pos_q    <= pos_d;
`ifdef STEP_RAMP_EN
            hold_q   <= hold_d;
`endif
        end
    end

    assign step_out = step_q;
    assign dir_out  = dir_q;
    assign busy     = (state_q != IDLE);
    assign position = pos_q;

endmodule
